// File: rtl/mem_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_streamer
// Brief    : Burst read master for pseudo_dual_port_memory. Issues credit-limited
//            reads and replays the fixed-latency returns as a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_LAT   = 2,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  r_avalid,
   input  logic                  r_dvalid,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy
);

   localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);
   localparam int c_ptr_w = $clog2(BUF_DEPTH);
   localparam logic [c_cnt_w:0]    c_depth_sum = (c_cnt_w + 1)'(BUF_DEPTH);
   localparam logic [c_cnt_w-1:0]  c_depth_cnt = c_cnt_w'(BUF_DEPTH);
   localparam logic [c_ptr_w-1:0]  c_last_ptr  = c_ptr_w'(BUF_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] c_len_one   = (ADDR_WIDTH + 1)'(1);

   generate
      if ((BUF_DEPTH < DATA_LAT + 2) || (DATA_LAT < 1)) begin : g_bad_params
         $error("mem_read_streamer: need DATA_LAT >= 1 and BUF_DEPTH >= DATA_LAT+2");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   logic                    r_cmd_ready;
   logic                    r_busy;
   logic [ADDR_WIDTH-1:0]   r_addr_q;
   logic [ADDR_WIDTH:0]     r_len_q;
   logic [ADDR_WIDTH:0]     r_rem_q;
   logic [ADDR_WIDTH:0]     r_out_cnt;
   logic [c_cnt_w-1:0]      r_inflight;
   logic [c_cnt_w-1:0]      r_count;
   logic [c_ptr_w-1:0]      r_wr_ptr;
   logic [c_ptr_w-1:0]      r_rd_ptr;
   logic [DATA_WIDTH-1:0]   r_buf [BUF_DEPTH];

   logic w_credit_ok;
   logic w_issue;
   logic w_pop;
   logic w_last_hs;

   // Credit is everything requested but not yet popped; same-cycle pops do not count.
   assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count}) < c_depth_sum;
   assign w_issue     = (r_state == S_ISSUE) && w_credit_ok;
   assign w_pop       = out_valid && out_ready;
   assign w_last_hs   = w_pop && out_last;

   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign r_avalid  = w_issue;
   assign r_addr    = r_addr_q;
   assign out_valid = (r_count != '0);
   assign out_data  = r_buf[r_rd_ptr];
   assign out_last  = out_valid && (r_out_cnt == (r_len_q - c_len_one));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_addr_q    <= '0;
         r_len_q     <= '0;
         r_rem_q     <= '0;
         r_out_cnt   <= '0;
      end else begin
         if (w_pop) begin
            r_out_cnt <= r_out_cnt + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && (cmd_len != '0)) begin
                  r_addr_q    <= cmd_base;
                  r_len_q     <= cmd_len;
                  r_rem_q     <= cmd_len;
                  r_out_cnt   <= '0;
                  r_state     <= S_ISSUE;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (w_issue) begin
                  r_addr_q <= r_addr_q + 1'b1;
                  r_rem_q  <= r_rem_q - 1'b1;
                  if (r_rem_q == c_len_one) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_last_hs) begin
                  r_state     <= S_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         case ({w_issue, r_dvalid})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
         case ({r_dvalid, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (r_dvalid) begin
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
         end
      end
   end

   // Returns cannot be refused, so the buffer accepts every r_dvalid.
   always_ff @(posedge clk) begin
      if (r_dvalid) begin
         r_buf[r_wr_ptr] <= r_data;
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(r_dvalid && (r_count == c_depth_cnt)));

endmodule
`default_nettype wire
